// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if
// Bundles the fetch controller's hazard, branch and IF/ID control signals.
//   master : hazard unit / ID stage side (drives stall, imemReady, branch, halt)
//   slave  : pc_fetch_ctrl side (drives pc, pcPlus, IF/ID controls, status)
// Signals:
//   stall        hold PC and IF/ID (ID operands not ready)
//   imemReady    instruction memory has valid data for pc this cycle
//   branchValid  ID instruction is a branch/jump, qualifies jmpTrue
//   jmpTrue      ID-stage comparator result
//   target       ID-stage computed branch target
//   halt         ID instruction decodes as halt
//   pc           registered fetch address
//   pcPlus       pc + step, for link/return values
//   ifidWrite    IF/ID load enable
//   ifidFlush    IF/ID loads a bubble instead of the fetched instruction
//   halted       controller is in the halt state
//   branchCount  taken branches since reset (wraps)
interface pc_fetch_ctrl_if;
    logic        stall;
    logic        imemReady;
    logic        branchValid;
    logic        jmpTrue;
    logic [15:0] target;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] pcPlus;
    logic        ifidWrite;
    logic        ifidFlush;
    logic        halted;
    logic [15:0] branchCount;

    modport master (
        output stall, imemReady, branchValid, jmpTrue, target, halt,
        input  pc, pcPlus, ifidWrite, ifidFlush, halted, branchCount
    );

    modport slave (
        input  stall, imemReady, branchValid, jmpTrue, target, halt,
        output pc, pcPlus, ifidWrite, ifidFlush, halted, branchCount
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
// Fetch-stage program counter and IF/ID control. Predict-not-taken: a taken
// branch resolved in ID redirects the PC and squashes the wrong-path fetch,
// costing one bubble. Also handles hazard stalls, imem wait states and halt.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  pc_fetch_ctrl_if slave modport (see interface for signal list)
module pc_fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_STEP  = 2
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_ctrl_if.slave  bus
);

    typedef enum logic [0:0] {StRun, StHalt} state_t;

    localparam logic [15:0] Step = 16'(PC_STEP);

    state_t      stateQ, stateD;
    logic [15:0] pcQ, pcD;
    logic [15:0] countQ, countD;
    logic        taken;

    assign taken = bus.branchValid & bus.jmpTrue;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateQ <= StRun;
            pcQ    <= RESET_PC;
            countQ <= 16'h0000;
        end else begin
            stateQ <= stateD;
            pcQ    <= pcD;
            countQ <= countD;
        end
    end

    // Next state and IF/ID controls. Default is "hold PC, load a bubble",
    // which covers reset, halt, the HALT state and imem wait states.
    always_comb begin
        stateD        = stateQ;
        pcD           = pcQ;
        countD        = countQ;
        bus.ifidWrite = 1'b1;
        bus.ifidFlush = 1'b1;

        if (rst) begin
            unique case (stateQ)
                StRun: begin
                    if (bus.stall) begin
                        // Branch/halt decision is not valid while stalled.
                        bus.ifidWrite = 1'b0;
                        bus.ifidFlush = 1'b0;
                    end else if (bus.halt) begin
                        stateD = StHalt;
                    end else if (taken) begin
                        // Redirect even if imem is waiting; that fetch is dropped.
                        pcD    = {bus.target[15:1], 1'b0};
                        countD = countQ + 16'h0001;
                    end else if (bus.imemReady) begin
                        pcD           = pcQ + Step;
                        bus.ifidFlush = 1'b0;
                    end
                end
                StHalt: begin
                    // Frozen until reset.
                end
                default: begin
                    stateD = StRun;
                end
            endcase
        end
    end

    assign bus.pc          = pcQ;
    assign bus.pcPlus      = pcQ + Step;
    assign bus.halted      = (stateQ == StHalt);
    assign bus.branchCount = countQ;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl
// Drives two controllers (reset PC 0x0000 and 0xFFFC) with the same stimulus:
// directed sequences from the test plan followed by random cycles, and
// compares every output each cycle against a behavioural model.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, imemReady, branchValid, jmpTrue, halt;
    logic [15:0] target;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl_if busA ();
    pc_fetch_ctrl_if busB ();

    assign busA.stall       = stall;
    assign busA.imemReady   = imemReady;
    assign busA.branchValid = branchValid;
    assign busA.jmpTrue     = jmpTrue;
    assign busA.target      = target;
    assign busA.halt        = halt;
    assign busB.stall       = stall;
    assign busB.imemReady   = imemReady;
    assign busB.branchValid = branchValid;
    assign busB.jmpTrue     = jmpTrue;
    assign busB.target      = target;
    assign busB.halt        = halt;

    pc_fetch_ctrl #(.RESET_PC(16'h0000), .PC_STEP(2)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    pc_fetch_ctrl #(.RESET_PC(16'hFFFC), .PC_STEP(2)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    logic [15:0] obsPc    [2];
    logic [15:0] obsPlus  [2];
    logic [15:0] obsCount [2];
    logic        obsWrite [2];
    logic        obsFlush [2];
    logic        obsHalted[2];

    assign obsPc[0]     = busA.pc;
    assign obsPc[1]     = busB.pc;
    assign obsPlus[0]   = busA.pcPlus;
    assign obsPlus[1]   = busB.pcPlus;
    assign obsCount[0]  = busA.branchCount;
    assign obsCount[1]  = busB.branchCount;
    assign obsWrite[0]  = busA.ifidWrite;
    assign obsWrite[1]  = busB.ifidWrite;
    assign obsFlush[0]  = busA.ifidFlush;
    assign obsFlush[1]  = busB.ifidFlush;
    assign obsHalted[0] = busA.halted;
    assign obsHalted[1] = busB.halted;

    // Behavioural model: plain integers per instance.
    int resetPc [2] = '{0, 'hFFFC};
    int mPc     [2];
    int mCount  [2];
    bit mHalted [2];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic setIn(input bit r, input bit st, input bit im, input bit bv, input bit jt,
                         input logic [15:0] tg, input bit h);
        rst = r; stall = st; imemReady = im; branchValid = bv; jmpTrue = jt;
        target = tg; halt = h;
    endtask

    // One clock cycle: check combinational and registered outputs, then
    // advance the model across the edge and let the DUT do the same.
    task automatic step();
        bit expW [2];
        bit expF [2];
        int nPc  [2];
        int nCnt [2];
        bit nHlt [2];
        #1;
        for (int i = 0; i < 2; i++) begin
            expW[i] = 1'b1;
            expF[i] = 1'b1;
            nPc[i]  = mPc[i];
            nCnt[i] = mCount[i];
            nHlt[i] = mHalted[i];
            if (!rst) begin
                nPc[i] = resetPc[i]; nCnt[i] = 0; nHlt[i] = 1'b0;
            end else if (mHalted[i]) begin
                // everything ignored
            end else if (stall) begin
                expW[i] = 1'b0; expF[i] = 1'b0;
            end else if (halt) begin
                nHlt[i] = 1'b1;
            end else if (branchValid && jmpTrue) begin
                nPc[i]  = target - (target % 2);
                nCnt[i] = (mCount[i] + 1) % 65536;
            end else if (imemReady) begin
                nPc[i]  = (mPc[i] + 2) % 65536;
                expF[i] = 1'b0;
            end
            checkVal($sformatf("ifidWrite[%0d]", i), 32'(obsWrite[i]), 32'(expW[i]));
            checkVal($sformatf("ifidFlush[%0d]", i), 32'(obsFlush[i]), 32'(expF[i]));
            checkVal($sformatf("pc[%0d]", i), 32'(obsPc[i]), 32'(mPc[i]));
            checkVal($sformatf("pcPlus[%0d]", i), 32'(obsPlus[i]), 32'((mPc[i] + 2) % 65536));
            checkVal($sformatf("halted[%0d]", i), 32'(obsHalted[i]), 32'(mHalted[i]));
            checkVal($sformatf("branchCount[%0d]", i), 32'(obsCount[i]), 32'(mCount[i]));
            checkVal($sformatf("noWriteFlush[%0d]", i), 32'(!obsWrite[i] && obsFlush[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            mPc[i] = nPc[i]; mCount[i] = nCnt[i]; mHalted[i] = nHlt[i];
        end
    endtask

    task automatic doReset();
        setIn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        step();
        setIn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic runSeq(input int n);
        setIn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        setIn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            mPc[i] = resetPc[i]; mCount[i] = 0; mHalted[i] = 1'b0;
        end

        // Sequential fetch: A 0,2,4,6,8; B FFFC,FFFE,0000,...
        doReset();
        runSeq(4);
        checkVal("seqPcA", 32'(busA.pc), 32'h0008);
        checkVal("seqPcB", 32'(busB.pc), 32'h0004);

        // Taken branch at pc 6.
        doReset();
        runSeq(3);
        setIn(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b0);
        step();
        checkVal("takenPc", 32'(busA.pc), 32'h0040);
        checkVal("takenCount", 32'(busA.branchCount), 32'd1);

        // Not-taken branch at pc 6.
        doReset();
        runSeq(3);
        setIn(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0040, 1'b0);
        step();
        checkVal("notTakenPc", 32'(busA.pc), 32'h0008);

        // Stall over a taken branch, then release.
        doReset();
        runSeq(3);
        setIn(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b0);
        step();
        checkVal("stallPc", 32'(busA.pc), 32'h0006);
        setIn(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b0);
        step();
        checkVal("releasePc", 32'(busA.pc), 32'h0040);

        // Memory wait at pc 4, then taken while waiting.
        doReset();
        runSeq(2);
        setIn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step();
        step();
        setIn(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 1'b0);
        step();
        checkVal("waitTakenPc", 32'(busA.pc), 32'h0020);

        // Halt at pc 0x10 together with a taken branch, then branches ignored.
        doReset();
        runSeq(8);
        setIn(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0080, 1'b1);
        step();
        for (int k = 0; k < 10; k++) begin
            setIn(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 1'b1,
                  16'($urandom), 1'($urandom_range(1)));
            step();
        end
        checkVal("haltPc", 32'(busA.pc), 32'h0010);
        checkVal("haltFlag", 32'(busA.halted), 32'd1);
        doReset();
        checkVal("postResetHalted", 32'(busA.halted), 32'd0);

        // Odd target is aligned.
        runSeq(1);
        setIn(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0031, 1'b0);
        step();
        checkVal("alignPc", 32'(busB.pc), 32'h0030);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            setIn(($urandom_range(31) != 0), ($urandom_range(5) == 0), ($urandom_range(3) != 0),
                  1'($urandom_range(1)), 1'($urandom_range(1)), 16'($urandom),
                  ($urandom_range(40) == 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

- Fetch-stage program-counter and IF/ID control block.
- Consumes the ID-stage branch decision (`jmpTrue` from the comparator) and the branch target, and redirects the PC.
- Squashes the wrong-path instruction in IF/ID and handles hazard stalls, instruction-memory wait states and halt.
- Sits upstream of the IF/ID pipeline register, fed back from the ID-stage compare logic.
- Uses predict-not-taken, so a taken branch costs one bubble.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- PC_STEP, 2, byte increment per sequential fetch (16-bit instructions)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- stall  in  1  hazard unit: hold PC and IF/ID (ID operands not ready)
- imemReady  in  1  instruction memory has valid data for `pc` this cycle
- branchValid  in  1  ID instruction is a branch/jump; qualifies `jmpTrue`
- jmpTrue  in  1  ID-stage comparator result
- target  in  16  ID-stage computed branch target
- halt  in  1  ID instruction decodes as halt
- pc  out  16  fetch address to instruction memory (registered)
- pcPlus  out  16  `pc + PC_STEP`, mod 2^16, for link/return values
- ifidWrite  out  1  IF/ID register load enable
- ifidFlush  out  1  IF/ID loads a bubble (NOP) instead of fetched instruction
- halted  out  1  block is in HALT state (registered)
- branchCount  out  16  number of taken branches since reset (registered, wraps)

## Operation
- States: RUN, HALT. `taken = branchValid & jmpTrue`.
- In RUN, per-cycle priority (first match wins):
  - 1. `stall=1`: `pc` holds, `ifidWrite=0`, `ifidFlush=0`. `halt`/`taken` ignored because the comparison is invalid; `branchCount` unchanged.
  - 2. `halt=1`: `pc` holds, `ifidWrite=1`, `ifidFlush=1`, next state HALT. Halt beats `taken`.
  - 3. `taken`: `pc <= {target[15:1],1'b0}` (bit 0 forced low), `ifidWrite=1`, `ifidFlush=1`, `branchCount++`. Applies even when `imemReady=0`; the outstanding fetch is abandoned.
  - 4. `imemReady=0`: `pc` holds, `ifidWrite=1`, `ifidFlush=1` (bubble inserted).
  - 5. Otherwise: `pc <= pc + PC_STEP`, `ifidWrite=1`, `ifidFlush=0`.
- In HALT:
  - `pc` frozen; `ifidWrite=1`, `ifidFlush=1`; `halted=1`.
  - All inputs except `rst` ignored. Exit only via reset.
- Arithmetic: PC add is 16-bit modulo (0xFFFE + 2 = 0x0000). `branchCount` wraps 0xFFFF to 0x0000.
- `pcPlus` is combinational from `pc`.

## Timing
- `rst=0` at a rising edge sets `pc=RESET_PC`, state RUN, `halted=0`, `branchCount=0`.
- While `rst=0`: `ifidWrite=1`, `ifidFlush=1`, so IF/ID is loaded with a bubble.
- Reset overrides everything, including a taken branch or halt in the same cycle.
- `ifidWrite` and `ifidFlush` are combinational from state and the same-cycle inputs. They act on the same edge that updates `pc`.
- Taken-branch latency:
  - Branch seen in cycle N: the wrong-path instruction is squashed at edge N, and `pc=target` in cycle N+1.
  - The target instruction enters IF/ID at edge N+1, so the penalty is exactly one bubble.
- Halt seen in cycle N: `halted=1` from cycle N+1; `pc` keeps its cycle-N value.
- Stall released in cycle N+1 with the branch still in ID: the branch is evaluated normally in N+1.
- `ifidWrite=0` and `ifidFlush=1` never occur together.

## Test plan
- Reset, then 4 cycles with `imemReady=1` and other inputs 0 -> `pc` = 0x0000, 0x0002, 0x0004, 0x0006, 0x0008; `ifidWrite=1`, `ifidFlush=0`, `pcPlus=pc+2`.
- Branch at `pc`=0x0006:
  - `branchValid=1`, `jmpTrue=1`, `target=0x0040` -> `ifidFlush=1` that cycle; next `pc=0x0040`; `branchCount=1`.
  - Same with `jmpTrue=0` -> next `pc=0x0008`, no flush.
- Stall over a branch at `pc`=0x0006:
  - `stall=1` plus taken, `target=0x0040` -> `pc` stays 0x0006, `ifidWrite=0`, `ifidFlush=0`, `branchCount=0`.
  - Next cycle `stall=0` -> `pc=0x0040`, `branchCount=1`.
- Memory wait at `pc`=0x0004:
  - `imemReady=0` for 2 cycles -> `pc` holds 0x0004, `ifidFlush=1` both cycles.
  - Taken with `target=0x0020` while `imemReady=0` -> next `pc=0x0020`.
- Halt at `pc`=0x0010:
  - `halt=1` together with taken -> `halted=1` next cycle, `pc` frozen at 0x0010 for 10 cycles with further branches ignored.
  - One cycle of `rst=0` -> `pc=0x0000`, `halted=0`, `branchCount=0`.
- Wrap and alignment, with `RESET_PC=16'hFFFC`:
  - Sequential run -> `pc` = 0xFFFC, 0xFFFE, 0x0000.
  - Taken with `target=0x0031` -> `pc=0x0030`.
